// File: rtl/sensor_capture.sv
// sensor_capture
//   Captures a line/frame-structured sensor stream and turns it into a byte
//   stream for a ring FIFO write port. Each captured frame is followed by a
//   four-byte trailer: A5, 5A, frame number (low byte), status
//   {6'b0, frame_err, line_err}.
//
//   Parameters
//     LINE_PIXELS  pixels per sensor line
//     FRAME_LINES  lines per frame
//     PIX_WIDTH    sensor pixel bus width (>= 8); the 8 MSBs are captured
//
//   Ports
//     wr_clk      single clock, all inputs sampled on the rising edge
//     rst         synchronous active-high reset
//     enable      capture enable
//     fval/lval   sensor frame / line valid
//     pix_data    sensor pixel data
//     wr_en/din   byte strobe and byte to the FIFO write port
//     frame_cnt   completed frame count (wraps)
//     busy        high while a frame or its trailer is in progress
//     frame_done  one-cycle pulse with the last trailer byte
//     err_sticky  set by any line/frame length error, cleared only by rst
//
//   Build option
//     SENSOR_TESTPAT_EN  replaces pixel bytes by a per-frame incrementing
//                        byte counter; timing, trailer and errors unchanged.
module sensor_capture #(
    parameter int LINE_PIXELS = 608,
    parameter int FRAME_LINES = 64,
    parameter int PIX_WIDTH   = 10
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fval,
    input  logic                 lval,
    input  logic [PIX_WIDTH-1:0] pix_data,
    output logic                 wr_en,
    output logic [7:0]           din,
    output logic [15:0]          frame_cnt,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err_sticky
);

    localparam int PW = $clog2(LINE_PIXELS + 1);
    // One spare count above FRAME_LINES so an extra line is still visible.
    localparam int LW = $clog2(FRAME_LINES + 2);
    localparam logic [PW-1:0] PIX_TARGET  = PW'(LINE_PIXELS);
    localparam logic [LW-1:0] LINE_TARGET = LW'(FRAME_LINES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2,
        TRAILER = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic                   fval_q, fval_d;
    logic                   fval_prev_q, fval_prev_d;
    logic                   lval_q, lval_d;
    logic                   lval_prev_q, lval_prev_d;
    logic [PIX_WIDTH-1:0]   pix_q, pix_d;
    logic [1:0]             hist_q, hist_d;
    logic [PW-1:0]          pix_cnt_q, pix_cnt_d;
    logic [LW-1:0]          line_cnt_q, line_cnt_d;
    logic                   line_err_q, line_err_d;
    logic                   frame_err_q, frame_err_d;
    logic [1:0]             trl_cnt_q, trl_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [7:0]             din_q, din_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_sticky_q, err_sticky_d;
`ifdef SENSOR_TESTPAT_EN
    logic [7:0]             tp_cnt_q, tp_cnt_d;
`endif

    logic                   fval_rise, fval_fall, lval_fall;
    logic                   unused_pix;

    // Edges are only trusted once both fval_q and fval_prev_q hold real
    // post-reset samples; otherwise a frame already running across reset
    // would look like a fresh rising edge and be captured part-way through.
    always_comb begin
        fval_rise = hist_q[1] &  fval_q & ~fval_prev_q;
        fval_fall = hist_q[1] & ~fval_q &  fval_prev_q;
        lval_fall = hist_q[1] & ~lval_q &  lval_prev_q;
    end

    // Low pixel bits (all bits in test-pattern builds) are deliberately unused.
    always_comb begin
        unused_pix = ^pix_q;
    end

    always_comb begin
        fval_d       = fval;
        lval_d       = lval;
        pix_d        = pix_data;
        fval_prev_d  = fval_q;
        lval_prev_d  = lval_q;
        hist_d       = {hist_q[0], 1'b1};

        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        line_err_d   = line_err_q;
        frame_err_d  = frame_err_q;
        trl_cnt_d    = trl_cnt_q;
        wr_en_d      = 1'b0;
        din_d        = din_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;
        err_sticky_d = err_sticky_q;
`ifdef SENSOR_TESTPAT_EN
        tp_cnt_d     = tp_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ARMED;
                end
            end

            ARMED: begin
                if (fval_rise) begin
                    state_d = ACTIVE;
                end
            end

            ACTIVE: begin
                if (lval_q) begin
                    wr_en_d = 1'b1;
`ifdef SENSOR_TESTPAT_EN
                    din_d    = tp_cnt_q;
                    tp_cnt_d = tp_cnt_q + 8'd1;
`else
                    din_d    = pix_q[PIX_WIDTH-1 -: 8];
`endif
                    if (pix_cnt_q != '1) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end

                if (lval_fall) begin
                    if (line_cnt_q != '1) begin
                        line_cnt_d = line_cnt_q + 1'b1;
                    end
                    if (pix_cnt_q != PIX_TARGET) begin
                        line_err_d = 1'b1;
                    end
                    pix_cnt_d = '0;
                end

                // line_cnt_d already includes a line ending in this same cycle.
                if (fval_fall) begin
                    state_d   = TRAILER;
                    trl_cnt_d = '0;
                    if (line_cnt_d != LINE_TARGET) begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            TRAILER: begin
                wr_en_d   = 1'b1;
                trl_cnt_d = trl_cnt_q + 2'd1;
                unique case (trl_cnt_q)
                    2'd0:    din_d = 8'hA5;
                    2'd1:    din_d = 8'h5A;
                    2'd2:    din_d = frame_cnt_q[7:0];
                    default: din_d = {6'b0, frame_err_q, line_err_q};
                endcase

                if (trl_cnt_q == 2'd3) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 16'd1;
                    err_sticky_d = err_sticky_q | frame_err_q | line_err_q;
                    state_d      = enable ? ARMED : IDLE;
                    pix_cnt_d    = '0;
                    line_cnt_d   = '0;
                    line_err_d   = 1'b0;
                    frame_err_d  = 1'b0;
                    trl_cnt_d    = '0;
`ifdef SENSOR_TESTPAT_EN
                    tp_cnt_d     = '0;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ACTIVE) || (state_d == TRAILER);
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            fval_q       <= 1'b0;
            fval_prev_q  <= 1'b0;
            lval_q       <= 1'b0;
            lval_prev_q  <= 1'b0;
            pix_q        <= '0;
            hist_q       <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            trl_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            din_q        <= '0;
            frame_cnt_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_sticky_q <= 1'b0;
`ifdef SENSOR_TESTPAT_EN
            tp_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fval_q       <= fval_d;
            fval_prev_q  <= fval_prev_d;
            lval_q       <= lval_d;
            lval_prev_q  <= lval_prev_d;
            pix_q        <= pix_d;
            hist_q       <= hist_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
            trl_cnt_q    <= trl_cnt_d;
            wr_en_q      <= wr_en_d;
            din_q        <= din_d;
            frame_cnt_q  <= frame_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_sticky_q <= err_sticky_d;
`ifdef SENSOR_TESTPAT_EN
            tp_cnt_q     <= tp_cnt_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign din        = din_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_sensor_capture.sv
// Scoreboard bench for sensor_capture (LINE_PIXELS=4, FRAME_LINES=2,
// PIX_WIDTH=10). Stimulus tasks push the expected byte stream; the monitor
// pops it whenever wr_en is seen.
module tb_sensor_capture;

    localparam int LP  = 4;
    localparam int FL  = 2;
    localparam int PWD = 10;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           fval;
    logic           lval;
    logic [PWD-1:0] pix_data;
    logic           wr_en;
    logic [7:0]     din;
    logic [15:0]    frame_cnt;
    logic           busy;
    logic           frame_done;
    logic           err_sticky;

    sensor_capture #(
        .LINE_PIXELS (LP),
        .FRAME_LINES (FL),
        .PIX_WIDTH   (PWD)
    ) dut (
        .wr_clk     (clk),
        .rst        (rst),
        .enable     (enable),
        .fval       (fval),
        .lval       (lval),
        .pix_data   (pix_data),
        .wr_en      (wr_en),
        .din        (din),
        .frame_cnt  (frame_cnt),
        .busy       (busy),
        .frame_done (frame_done),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         t;     // expected cycle of appearance, -1 = not checked
        bit         last;  // frame_done expected with this byte
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cmp_cnt  = 0;
    int         err_cnt  = 0;
    int         fc_m     = 0;
    bit         sticky_m = 1'b0;
    int         tp_m     = 0;
    logic [9:0] pix_tab[4] = '{10'h3FC, 10'h004, 10'h200, 10'h1FF};

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Output bytes appear two negedges after the pixel was driven.
    task automatic push_pix(input logic [9:0] p);
        exp_t e;
`ifdef SENSOR_TESTPAT_EN
        e.b = 8'(tp_m);
        tp_m++;
`else
        e.b = 8'(p / 10'd4);
`endif
        e.t    = cyc + 2;
        e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_trailer(input int status);
        exp_t e;
        e.t    = -1;
        e.last = 1'b0;
        e.b = 8'hA5;             exp_q.push_back(e);
        e.b = 8'h5A;             exp_q.push_back(e);
        e.b = 8'(fc_m % 256);    exp_q.push_back(e);
        e.b = 8'(status);
        e.last = 1'b1;           exp_q.push_back(e);
        fc_m     = (fc_m + 1) % 65536;
        sticky_m = sticky_m | (status != 0);
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_byte: got din=0x%0h expected no write (t=%0t)", din, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("din", int'(din), int'(mon_e.b));
                chk("frame_done", int'(frame_done), int'(mon_e.last));
                if (mon_e.t >= 0) chk("pix_latency", cyc, mon_e.t);
            end
        end else if (frame_done !== 1'b0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL frame_done_nowrite: got %b expected 0 (t=%0t)", frame_done, $time);
        end
    end

    task automatic run_frame(input int nl, input int lens[4], input bit capt,
                             input bit same_fall, input bit use_tab,
                             input int en_line, input bit en_val);
        int status;
        logic [9:0] v;
        status = (nl != FL) ? 2 : 0;
        for (int i = 0; i < nl; i++) if (lens[i] != LP) status = status | 1;
        tp_m = 0;
        fval = 1'b1;
        lval = 1'b0;
        @(negedge clk);
        for (int li = 0; li < nl; li++) begin
            if (li == en_line) enable = en_val;
            for (int p = 0; p < lens[li]; p++) begin
                v = use_tab ? pix_tab[p % 4] : 10'($urandom);
                lval     = 1'b1;
                pix_data = v;
                if (capt) push_pix(v);
                if (li == 1 && p == 0) chk("busy", int'(busy), int'(capt));
                @(negedge clk);
            end
            lval = 1'b0;
            pix_data = 10'($urandom);
            if (li == nl - 1 && same_fall) begin
                fval = 1'b0;
                if (capt) push_trailer(status);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        if (!same_fall) begin
            fval = 1'b0;
            if (capt) push_trailer(status);
        end
        repeat (8) @(negedge clk);
        if (capt) begin
            chk("frame_cnt", int'(frame_cnt), fc_m);
            chk("err_sticky", int'(err_sticky), int'(sticky_m));
        end
    endtask

    initial begin
        int lens[4];
        rst = 1'b1; enable = 1'b0; fval = 1'b0; lval = 1'b0; pix_data = '0;
        repeat (2) begin
            @(negedge clk);
            pix_data = 10'($urandom);
            lval     = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_din", int'(din), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_err_sticky", int'(err_sticky), 0);
        rst = 1'b0; lval = 1'b0;
        repeat (3) @(negedge clk);

        // enable rises while a frame is running: nothing captured
        run_frame(2, '{4, 4, 0, 0}, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        // nominal frame with fixed pixels
        run_frame(2, '{4, 4, 0, 0}, 1'b1, 1'b0, 1'b1, -1, 1'b0);
        // short second line, then a good frame
        run_frame(2, '{4, 3, 0, 0}, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_frame(2, '{4, 4, 0, 0}, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        // fval and lval fall together: last line still counted
        run_frame(3, '{4, 4, 4, 0}, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        run_frame(2, '{4, 4, 0, 0}, 1'b1, 1'b1, 1'b0, -1, 1'b0);
        // enable dropped mid-frame: frame completes, then no capture
        run_frame(2, '{4, 4, 0, 0}, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        run_frame(2, '{4, 4, 0, 0}, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        enable = 1'b1;
        repeat (2) @(negedge clk);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) lens[i] = $urandom_range(3, 5);
            run_frame($urandom_range(1, 3), lens, 1'b1, 1'($urandom), 1'b0, -1, 1'b0);
        end

        // reset after five pixel bytes
        tp_m = 0;
        fval = 1'b1; lval = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 6; p++) begin
            if (p == 4) begin
                lval = 1'b0;
                repeat (2) @(negedge clk);
            end
            lval = 1'b1;
            pix_data = 10'($urandom);
            push_pix(pix_data);
            @(negedge clk);
        end
        rst = 1'b1;
        pix_data = 10'($urandom);
        @(negedge clk);
        chk("midrst_wr_en", int'(wr_en), 0);
        chk("midrst_frame_cnt", int'(frame_cnt), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_sticky", int'(err_sticky), 0);
        chk("midrst_bytes_before", exp_q.size(), 1);
        exp_q.delete();
        fc_m = 0;
        sticky_m = 1'b0;
        rst = 1'b0;
        // rest of the interrupted frame must produce nothing
        for (int p = 0; p < 4; p++) begin
            lval = 1'b1;
            pix_data = 10'($urandom);
            @(negedge clk);
        end
        lval = 1'b0;
        repeat (2) @(negedge clk);
        fval = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_no_trailer", int'(frame_cnt), 0);
        run_frame(2, '{4, 4, 0, 0}, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sensor_capture.md
SENSOR_CAPTURE -- requirements
Module: sensor_capture

Interface
REQ-001 Parameter LINE_PIXELS, default 608, meaning pixels per sensor line.
REQ-002 Parameter FRAME_LINES, default 64, meaning lines per frame (608 x 64 = 38912 bytes per package).
REQ-003 Parameter PIX_WIDTH, default 10, meaning sensor pixel bus width (minimum 8).
REQ-004 wr_clk  input  1  single clock; all inputs are sampled on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  capture enable from control logic.
REQ-007 fval  input  1  sensor frame valid.
REQ-008 lval  input  1  sensor line valid.
REQ-009 pix_data  input  PIX_WIDTH  sensor pixel data.
REQ-010 wr_en  output  1  byte strobe to the ring FIFO write port.
REQ-011 din  output  8  byte to the ring FIFO write port.
REQ-012 frame_cnt  output  16  count of completed frames.
REQ-013 busy  output  1  high in ACTIVE or TRAILER.
REQ-014 frame_done  output  1  one-cycle pulse coincident with the last trailer byte.
REQ-015 err_sticky  output  1  set on any line or frame length error; cleared only by rst.

Function
REQ-016 The block SHALL register fval, lval and pix_data once (fval_q, lval_q, pix_q) before any use.
REQ-017 The FSM SHALL have exactly the states IDLE, ARMED, ACTIVE and TRAILER.
REQ-018 IDLE -> ARMED when enable=1; ARMED -> ACTIVE on a rising edge of fval_q (fval_q=1 with previous fval_q=0); a frame already in progress at arming SHALL be skipped entirely.
REQ-019 In ACTIVE, each cycle with lval_q=1 SHALL produce wr_en=1 on the following cycle, with din=pix_q[PIX_WIDTH-1:PIX_WIDTH-8]; pixel-to-din latency is 2 cycles from the pix_data sample.
REQ-020 Pixel counter: counts lval_q cycles in the current line, saturates at 2^W-1 with W=clog2(LINE_PIXELS+1), clears on every lval_q falling edge.
REQ-021 A lval_q falling edge SHALL increment the line counter (saturating); if the pixel count != LINE_PIXELS, the line error flag for that frame SHALL be set.
REQ-022 A fval_q falling edge in ACTIVE SHALL enter TRAILER; if lval_q falls in the same cycle, it SHALL be processed as a line end first.
REQ-023 Frame error: line count != FRAME_LINES at the fval_q falling edge.
REQ-024 TRAILER SHALL emit 4 consecutive bytes with wr_en=1: 0xA5, 0x5A, frame_cnt[7:0] (pre-increment), then {6'b0, frame_err, line_err}.
REQ-025 On the 4th trailer byte: frame_done=1, frame_cnt increments (wraps 0xFFFF -> 0), and err_sticky is set if either error flag is set.
REQ-026 After TRAILER the FSM SHALL go to ARMED if enable=1, else IDLE; the line counter, pixel counter and per-frame error flags SHALL clear.
REQ-027 enable=0 during ACTIVE SHALL NOT abort the frame; the trailer still completes.
REQ-028 wr_en SHALL be 0 in IDLE and ARMED, and in ACTIVE whenever lval_q was 0 on the previous cycle.
REQ-029 A fval_q rising edge during TRAILER SHALL be ignored; that frame is skipped.

Reset
REQ-030 rst=1 SHALL force, on the next edge: state=IDLE, wr_en=0, din=0x00, frame_cnt=0, busy=0, frame_done=0, err_sticky=0, all counters and flags 0, input registers 0.
REQ-031 rst asserted mid-frame or mid-trailer SHALL discard the partial output; no further bytes are emitted until the next full frame after re-arming.

Configuration
REQ-032 Macro SENSOR_TESTPAT_EN defined: in ACTIVE, din SHALL be the low 8 bits of a per-frame byte counter (starts at 0x00 each frame, increments per emitted pixel byte, wraps), ignoring pix_data; all timing, trailer bytes and error logic are unchanged.
REQ-033 Macro SENSOR_TESTPAT_EN undefined: din carries the pixel MSBs as in REQ-019, and no test-pattern logic is present.

Verification (LINE_PIXELS=4, FRAME_LINES=2, PIX_WIDTH=10)
REQ-034 Bench case 1: enable=1, one frame of 2 lines x 4 pixels, pix_data=0x3FC,0x004,0x200,0x1FF -> per line din=FF,01,80,7F, each 2 cycles after its sample; then A5,5A,00,00; frame_done pulses; frame_cnt=1.
REQ-035 Bench case 2: frame whose second line has 3 pixels -> trailer status byte=0x01; err_sticky=1 after the frame; next good frame still gives status 0x00 and err_sticky stays 1.
REQ-036 Bench case 3: frame of 3 good lines -> status byte=0x02; fval and lval falling in the same cycle -> the line is counted before the trailer.
REQ-037 Bench case 4: enable rises while fval=1 -> no bytes for that frame; the next frame is captured in full.
REQ-038 Bench case 5: rst pulsed after 5 pixel bytes -> wr_en=0 on the next cycle, frame_cnt=0, no trailer; re-arming resumes capture on the following frame.
REQ-039 Bench case 6: with SENSOR_TESTPAT_EN, two frames -> pixel bytes 00..07 in each frame; trailer 3rd byte is 00 then 01.
